// File: rtl/cw_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : cw_decoder
// Brief   : CW receive decoder; debounces key_n, times marks/spaces in 1 ms
//           ticks and emits character / word-gap records over valid/ready.
// Revision: 1.0  initial release
// ============================================================================
module cw_decoder #(
   parameter int DEB = 3,
   parameter int CW  = 13
) (
   input  logic       clk,
   input  logic       rstb,
   input  logic       tick1k,
   input  logic       key_n,
   input  logic [9:0] DotOnTime,
   output logic       char_valid,
   input  logic       char_ready,
   output logic [2:0] char_len,
   output logic [5:0] char_bits,
   output logic       overrun,
   output logic       key_db
);
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_MARK  = 2'd1,
      S_SPACE = 2'd2
   } state_t;

   localparam logic [2:0]    C_DEB = 3'(DEB);
   localparam logic [CW-1:0] C_ONE = CW'(1);
   localparam logic [CW-1:0] C_MAX = {CW{1'b1}};

   state_t        r_state, w_state_nxt;
   logic [2:0]    r_db_cnt, w_db_inc;
   logic          r_key_db;
   logic [CW-1:0] r_mark_cnt, w_mark_nxt, w_mark_inc;
   logic [CW-1:0] r_space_cnt, w_space_nxt, w_space_inc;
   logic [2:0]    r_n, w_n_nxt;
   logic [5:0]    r_sr, w_sr_nxt;
   logic          r_had, w_had_nxt;
   logic          w_push;
   logic [2:0]    w_push_len;
   logic [5:0]    w_push_bits;
   logic          r_valid, r_overrun;
   logic [2:0]    r_len;
   logic [5:0]    r_bits;
   logic          w_mark_in, w_diff, w_toggle, w_rise, w_fall, w_dash;
   logic [9:0]    w_d;
   logic [10:0]   w_t2;
   logic [12:0]   w_t5;
   logic [CW-1:0] w_t2c, w_t5c;

   // Debounce: key_db flips once the opposite level has been seen DEB ticks in a row
   assign w_mark_in = ~key_n;
   assign w_diff    = w_mark_in ^ r_key_db;
   assign w_db_inc  = r_db_cnt + 3'd1;
   assign w_toggle  = tick1k & w_diff & (w_db_inc == C_DEB);
   assign w_rise    = w_toggle & ~r_key_db;
   assign w_fall    = w_toggle & r_key_db;

   always_ff @(posedge clk) begin
      if (!rstb) begin
         r_db_cnt <= '0;
         r_key_db <= 1'b0;
      end else if (tick1k) begin
         r_db_cnt <= (!w_diff || w_toggle) ? 3'd0 : w_db_inc;
         if (w_toggle) r_key_db <= ~r_key_db;
      end
   end

   assign w_d         = (DotOnTime == 10'd0) ? 10'd1 : DotOnTime;
   assign w_t2        = {w_d, 1'b0};
   assign w_t5        = {1'b0, w_d, 2'b00} + {3'b000, w_d};
   assign w_t2c       = CW'(w_t2);
   assign w_t5c       = CW'(w_t5);
   assign w_mark_inc  = (r_mark_cnt == C_MAX) ? r_mark_cnt : r_mark_cnt + C_ONE;
   assign w_space_inc = (r_space_cnt == C_MAX) ? r_space_cnt : r_space_cnt + C_ONE;
   assign w_dash      = (r_mark_cnt >= w_t2c);

   always_comb begin
      w_state_nxt = r_state;
      w_mark_nxt  = r_mark_cnt;
      w_space_nxt = r_space_cnt;
      w_n_nxt     = r_n;
      w_sr_nxt    = r_sr;
      w_had_nxt   = r_had;
      w_push      = 1'b0;
      w_push_len  = 3'd0;
      w_push_bits = 6'd0;
      if (tick1k) begin
         case (r_state)
            S_IDLE: begin
               w_space_nxt = w_space_inc;
               if (r_had && (r_space_cnt == w_t5c)) begin
                  w_push    = 1'b1;
                  w_had_nxt = 1'b0;
               end
               if (w_rise) begin
                  w_state_nxt = S_MARK;
                  w_mark_nxt  = C_ONE;
               end
            end
            S_MARK: begin
               w_mark_nxt = w_mark_inc;
               if (w_fall) begin
                  if (r_n < 3'd6) w_sr_nxt = r_sr | ({5'b00000, w_dash} << r_n);
                  if (r_n != 3'd7) w_n_nxt = r_n + 3'd1;
                  w_state_nxt = S_SPACE;
                  w_space_nxt = C_ONE;
               end
            end
            S_SPACE: begin
               w_space_nxt = w_space_inc;
               if (r_space_cnt == w_t2c) begin
                  w_push      = 1'b1;
                  w_push_len  = r_n;
                  w_push_bits = r_sr;
                  w_had_nxt   = 1'b1;
                  w_n_nxt     = 3'd0;
                  w_sr_nxt    = 6'd0;
                  w_state_nxt = S_IDLE;
               end
               // A rise on the closing tick starts a fresh character after the push
               if (w_rise) begin
                  w_state_nxt = S_MARK;
                  w_mark_nxt  = C_ONE;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rstb) begin
         r_state     <= S_IDLE;
         r_mark_cnt  <= '0;
         r_space_cnt <= '0;
         r_n         <= 3'd0;
         r_sr        <= 6'd0;
         r_had       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_mark_cnt  <= w_mark_nxt;
         r_space_cnt <= w_space_nxt;
         r_n         <= w_n_nxt;
         r_sr        <= w_sr_nxt;
         r_had       <= w_had_nxt;
      end
   end

   // One-entry output buffer; a push into a full, unaccepted buffer is dropped
   always_ff @(posedge clk) begin
      if (!rstb) begin
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
         r_len     <= 3'd0;
         r_bits    <= 6'd0;
      end else if (w_push) begin
         if (!r_valid || char_ready) begin
            r_valid <= 1'b1;
            r_len   <= w_push_len;
            r_bits  <= w_push_bits;
         end else begin
            r_overrun <= 1'b1;
         end
      end else if (r_valid && char_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign char_valid = r_valid;
   assign char_len   = r_len;
   assign char_bits  = r_bits;
   assign overrun    = r_overrun;
   assign key_db     = r_key_db;
endmodule
`default_nettype wire

// File: doc/cw_decoder.md
# cw_decoder

Receive-side companion to the iambic keyer. It takes a keyed CW on/off signal, measures mark and space durations in 1 ms ticks, and classifies each element as dot or dash. Completed characters and word gaps are delivered to the host/command path as records through a one-entry valid/ready buffer. It runs in the `clk` domain and shares the keyer's 1 ms strobe and dot-length setting.

## Interface
Parameters:
- `DEB`, 3: debounce length in ticks; `key_n` must be stable this many consecutive ticks before a level is accepted (legal 1..7).
- `CW`, 13: width of the mark/space counters; counters saturate at 2^CW-1.

Ports:
- `clk`  in  1  system clock, same domain as the keyer.
- `rstb`  in  1  synchronous, active-low reset.
- `tick1k`  in  1  1 ms strobe, one `clk` wide (the keyer's `do1k`).
- `key_n`  in  1  keyed input, active low (0 = mark).
- `DotOnTime`  in  10  dot length in ms; a value of 0 is treated as 1.
- `char_valid`  out  1  output record valid.
- `char_ready`  in  1  consumer accepts the record when `char_valid & char_ready`.
- `char_len`  out  3  element count: 0 = word gap, 1..6 = character, 7 = overlong character.
- `char_bits`  out  6  elements in order, first element at bit 0; 1 = dash, 0 = dot; unused bits are 0.
- `overrun`  out  1  sticky; set when a record is dropped because the buffer is full; cleared only by reset.
- `key_db`  out  1  debounced key, active high (1 = mark).

## Operation
- All logic updates only on `clk` edges where `tick1k` = 1. The exceptions are the handshake and the `rstb` reset, which act on every `clk` edge.
- Reset (`rstb` = 0 on any edge, including mid-character) sets every output to 0 and returns the FSM to IDLE. It also clears the counters, the debounce counter, the element shift register and the `had_char` flag.
- Debounce:
  - A 3-bit counter increments each tick while the sampled `key_n` differs from `key_db`, and clears when they agree.
  - When the counter reaches `DEB`, `key_db` toggles and the counter clears.
- Derived thresholds, with D = max(`DotOnTime`, 1):
  - T2 = 2·D (11 bits)
  - T5 = 5·D (13 bits)
  - All comparisons are unsigned at CW bits.
- FSM states:
  - IDLE:
    - The shift register is empty.
    - On a `key_db` rise, go to MARK with mark_cnt = 1.
    - space_cnt keeps counting (saturating) for word-gap detection.
  - MARK:
    - mark_cnt increments each tick, saturating.
    - On a `key_db` fall, classify the element: dash if mark_cnt ≥ T2, else dot.
    - Append the element at index n and increment n. If n is already 6, n becomes 7 and no bit is stored.
    - Go to SPACE with space_cnt = 1.
  - SPACE:
    - space_cnt increments each tick, saturating.
    - A `key_db` rise before T2 returns to MARK (same character).
    - At space_cnt == T2, push a character record {n, bits}, set `had_char`, clear the shift register and go to IDLE.
- Word gap: in IDLE, at space_cnt == T5 with `had_char` = 1, push a record {len = 0, bits = 0} and clear `had_char`.
  - The exact-equality check fires once per gap. Saturation never re-fires it.
- Output buffer:
  - A push with the buffer empty loads the record and sets `char_valid`.
  - A push while `char_valid` = 1 and `char_ready` = 0 drops the new record, sets `overrun`, and leaves the held record unchanged.
  - A push in the same cycle as an accept loads the new record and keeps `char_valid` = 1, with no overrun.
  - `char_len`/`char_bits` are stable while `char_valid` = 1.
- A mark held past saturation stays in MARK and is classified as a dash on release.

## Timing
- Key edge to `key_db` change: `DEB` ticks after the first tick sampling the new level.
- Element classified on the tick `key_db` falls.
- Record push on the tick space_cnt reaches T2 (or T5 for a word gap).
- `char_valid` rises on the following `clk` edge, so output latency is one `clk` after the push tick.
- Accept: `char_valid` falls on the `clk` edge after `char_valid & char_ready`, unless a push coincides with it.
- `char_ready` may be held high permanently; the buffer then drains every cycle.
- `tick1k` and a handshake may coincide; both take effect in that cycle.

## Test plan
- `DotOnTime`=50, `DEB`=3, 1 ms ticks. Send "A": mark 50, space 50, mark 150, release; `char_ready`=1. Expect one record `char_len`=2, `char_bits`=6'b000010, 100 ms after the final debounced release.
- After the "A", hold space 300 ms. Expect a second record `char_len`=0 at space 250 ms. Expect no further record through 1000 ms of space.
- Send 8 dots, 50 ms on / 50 ms off. Expect `char_len`=7, `char_bits`=6'b000000.
- `char_ready`=0; send "E" (mark 50) then "T" (mark 150), separated by 150 ms of space. Expect the "E" record held (`char_len`=1, bits 0) and `overrun`=1 when "T" would have been pushed. Raise `char_ready`: "E" drains, and no "T" record appears.
- `key_n` glitches low for 2 ms every 20 ms. Expect `key_db` to stay 0 and no records.
- Assert `rstb`=0 for one `clk` mid-mark of "A". Expect all outputs 0, and no record until a fresh character completes.
- `DotOnTime`=0: mark 2 ms → dash, mark 1 ms → dot; push at space 2 ms.
